uart_alu_ctrl: RTL
==================

Name: uart_alu_ctrl

Overview:
Command sequencer between the UART receive/transmit FIFOs and an ALU datapath. It pops a 3-byte frame (operand A, operand B, opcode) from the RX FIFO and computes the result. It then pushes one result byte into the TX FIFO. The block sits directly downstream of the RX FIFO and upstream of the TX FIFO; the UART top instantiates it in the ALU slot.

Parameters:
DBIT, 8, UART/FIFO word width in bits
N, 8, ALU operand/result width in bits; N <= DBIT, operands taken from rx_data[N-1:0]

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset; all state cleared while low
rx_data  in  DBIT  head word of RX FIFO; valid whenever rx_empty=0 (first-word fall-through)
rx_empty  in  1  RX FIFO empty flag
rd_uart  out  1  RX FIFO pop strobe; one word consumed per clk cycle it is high
tx_data  out  DBIT  word presented to TX FIFO; result zero-extended from N to DBIT
tx_full  in  1  TX FIFO full flag
wr_uart  out  1  TX FIFO push strobe; one word written per clk cycle it is high
busy  out  1  high in any state other than GET_A
err_op  out  1  sticky; set by an unknown opcode, cleared only by reset

Behaviour:
- Reset (reset=0, asynchronous): state=GET_A; A, B, OP and result registers=0; tx_data=0; err_op=0; busy=0. rd_uart and wr_uart are 0 during reset.
- States: GET_A, GET_B, GET_OP, COMPUTE, SEND.
- GET_A/GET_B/GET_OP behaviour:
  - rd_uart = ~rx_empty (combinational).
  - When rx_empty=0, latch rx_data[N-1:0] into A/B/OP and advance to the next state.
  - When rx_empty=1, hold the state with rd_uart=0.
  - At most one pop per cycle; exactly one pop per latched byte.
- COMPUTE (1 cycle): result register <= alu(A,B,OP); go to SEND. rd_uart=0.
- SEND behaviour:
  - wr_uart = ~tx_full (combinational); tx_data = registered result.
  - When tx_full=0, push and return to GET_A.
  - When tx_full=1, stall indefinitely with tx_data stable.
  - rd_uart=0 throughout SEND, so no RX pops occur.
- Latency: the op-byte pop occurs in cycle t; the result is registered at t+1; the earliest wr_uart pulse is in cycle t+2.
- Throughput: one result per 5 cycles when the RX FIFO is never empty and the TX FIFO is never full.
- ALU rules (N-bit, results truncated to N bits, wrap-around, no carry/overflow outputs):
  - 0x20 ADD: A+B mod 2^N.
  - 0x22 SUB: A-B mod 2^N.
  - 0x24 AND; 0x25 OR; 0x26 XOR; 0x27 NOR.
  - 0x03 SRA: A arithmetic-shifted right by B. If B >= N, result is all copies of A[N-1].
  - 0x02 SRL: A logically shifted right by B. If B >= N, result is 0.
  - Any other opcode: result=0 and err_op<=1 in COMPUTE; the zero result is still sent, so frame alignment is preserved.
- The opcode is compared on OP[N-1:0] zero-extended to 8 bits.
- Reset mid-frame: any partially collected A/B is discarded. The next three bytes popped after reset release form a new frame. A result pending in SEND is dropped.
- busy = (state != GET_A).

Decomposition:
- Shared package uart_alu_pkg holds:
  - opcode constants (OP_ADD=8'h20, OP_SUB=8'h22, OP_AND=8'h24, OP_OR=8'h25, OP_XOR=8'h26, OP_NOR=8'h27, OP_SRA=8'h03, OP_SRL=8'h02);
  - state encoding (3-bit localparams).
- One sub-module, alu_core: purely combinational, parameter N.
  - Inputs: a, b, op. Outputs: result, op_valid.
  - uart_alu_ctrl registers result in COMPUTE and sets err_op from ~op_valid.

Test Plan:
- ADD: push 0x05,0x03,0x20 into RX model, tx_full=0 -> exactly 3 rd_uart pulses, then one wr_uart pulse with tx_data=0x08 two cycles after the opcode pop; err_op=0.
- SUB wrap and shifts: frames (0x03,0x05,0x22), (0x80,0x03,0x03), (0x80,0x09,0x02) -> tx_data sequence 0xFE, 0xF0, 0x00 in order.
- Starved RX: bytes 0x0F,0xF0,0x25 arrive with 7-cycle gaps -> rd_uart never high while rx_empty=1; busy high from the first pop; result 0xFF sent once.
- TX backpressure: tx_full=1 for 10 cycles after COMPUTE, frame (0xAA,0x55,0x26) -> wr_uart low for those 10 cycles, no RX pops, tx_data held at 0xFF, then a single push.
- Bad opcode: frame (0x01,0x02,0x11) -> tx_data=0x00 pushed, err_op=1. Following frame (0x01,0x02,0x20) -> 0x03 pushed and err_op remains 1 until reset.
- Reset mid-frame: pop 0x11,0x22, assert reset low for 2 cycles asynchronously, then feed 0x04,0x02,0x20 -> all outputs 0 during reset; the single result after release is 0x06.

Source files
------------

// File: rtl/uart_alu_pkg.sv
// Shared opcode constants and sequencer state encoding for the UART ALU slot.
package uart_alu_pkg;

    localparam logic [7:0] OP_ADD = 8'h20;
    localparam logic [7:0] OP_SUB = 8'h22;
    localparam logic [7:0] OP_AND = 8'h24;
    localparam logic [7:0] OP_OR  = 8'h25;
    localparam logic [7:0] OP_XOR = 8'h26;
    localparam logic [7:0] OP_NOR = 8'h27;
    localparam logic [7:0] OP_SRA = 8'h03;
    localparam logic [7:0] OP_SRL = 8'h02;

    localparam logic [2:0] ST_GET_A    = 3'd0;
    localparam logic [2:0] ST_GET_B    = 3'd1;
    localparam logic [2:0] ST_GET_OP   = 3'd2;
    localparam logic [2:0] ST_COMPUTE  = 3'd3;
    localparam logic [2:0] ST_SEND     = 3'd4;

    typedef enum logic [2:0] {
        GET_A   = ST_GET_A,
        GET_B   = ST_GET_B,
        GET_OP  = ST_GET_OP,
        COMPUTE = ST_COMPUTE,
        SEND    = ST_SEND
    } state_t;

endpackage

// File: rtl/uart_alu_ctrl_alu_core.sv
// Combinational N-bit ALU; op_valid drops for any opcode outside the supported set.
module alu_core
    import uart_alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] op,
    output logic [N-1:0] result,
    output logic         op_valid
);

    // Opcode is matched zero-extended, so wide operands with high bits set never alias.
    localparam int W = (N > 8) ? N : 8;
    localparam logic [N:0] N_VAL = (N+1)'(N);

    logic [W-1:0] op_x;
    logic         shift_big;

    assign op_x      = W'(op);
    assign shift_big = ({1'b0, b} >= N_VAL);

    always_comb begin
        result   = '0;
        op_valid = 1'b1;
        case (op_x)
            W'(OP_ADD): result = a + b;
            W'(OP_SUB): result = a - b;
            W'(OP_AND): result = a & b;
            W'(OP_OR):  result = a | b;
            W'(OP_XOR): result = a ^ b;
            W'(OP_NOR): result = ~(a | b);
            W'(OP_SRA): result = shift_big ? {N{a[N-1]}} : $unsigned($signed(a) >>> b);
            W'(OP_SRL): result = shift_big ? '0 : (a >> b);
            default:    op_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/uart_alu_ctrl.sv
// Frame sequencer: pops A, B, opcode from the RX FIFO, computes, pushes one result byte.
//   state   | meaning
//   GET_A   | idle, waiting for operand A
//   GET_B   | waiting for operand B
//   GET_OP  | waiting for opcode
//   COMPUTE | register ALU result, update err_op
//   SEND    | push result, stall while TX FIFO full
module uart_alu_ctrl
    import uart_alu_pkg::*;
#(
    parameter int DBIT = 8,
    parameter int N    = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [DBIT-1:0] rx_data,
    input  logic            rx_empty,
    output logic            rd_uart,
    output logic [DBIT-1:0] tx_data,
    input  logic            tx_full,
    output logic            wr_uart,
    output logic            busy,
    output logic            err_op
);

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   op_q, op_d;
    logic [N-1:0]   res_q, res_d;
    logic           err_q, err_d;
    logic [N-1:0]   alu_res;
    logic           alu_valid;
    logic           in_get;

    alu_core #(.N(N)) u_alu (
        .a        (a_q),
        .b        (b_q),
        .op       (op_q),
        .result   (alu_res),
        .op_valid (alu_valid)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            GET_A: if (!rx_empty) begin
                a_d     = rx_data[N-1:0];
                state_d = GET_B;
            end
            GET_B: if (!rx_empty) begin
                b_d     = rx_data[N-1:0];
                state_d = GET_OP;
            end
            GET_OP: if (!rx_empty) begin
                op_d    = rx_data[N-1:0];
                state_d = COMPUTE;
            end
            COMPUTE: begin
                res_d   = alu_res;
                err_d   = err_q | ~alu_valid;
                state_d = SEND;
            end
            SEND: if (!tx_full) state_d = GET_A;
            default: state_d = GET_A;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= GET_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    // Strobes are gated by reset so no FIFO traffic leaks out while it is held.
    assign in_get  = (state_q == GET_A) || (state_q == GET_B) || (state_q == GET_OP);
    assign rd_uart = reset & in_get & ~rx_empty;
    assign wr_uart = reset & (state_q == SEND) & ~tx_full;
    assign tx_data = DBIT'(res_q);
    assign busy    = (state_q != GET_A);
    assign err_op  = err_q;

endmodule
